// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response handshake bundle for the M-extension unit.
//               The master side issues operations and consumes results; the
//               slave side is the muldiv_unit itself.
// Ports       : req_valid/req_ready/req_funct3/req_a/req_b/req_tag - request
//               flush                                               - kill
//               resp_valid/resp_ready/resp_result/resp_tag          - response
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_funct3, req_a, req_b, req_tag, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_tag
  );

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, req_tag, flush, resp_ready,
    output req_ready, resp_valid, resp_result, resp_tag
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/
//               DIV/DIVU/REM/REMU). Radix-2 shift-add multiplier, restoring
//               divider, optional single-cycle multiplier, tag passthrough
//               and flush.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - muldiv_unit_if slave (request, flush, response)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int FAST_MUL = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic [TAG_W-1:0]  r_tag;

  // --------------------------------------------------------------------------
  // Final result selection. For multiplies p is the unsigned 2*XLEN product;
  // for divides p holds {remainder, quotient} of the magnitudes.
  // --------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] finish_result(
    input logic [2:0]        op,
    input logic              neg,
    input logic [2*XLEN-1:0] p
  );
    logic [2*XLEN-1:0] pm;
    logic [XLEN-1:0]   sel;
    pm  = neg ? (2*XLEN)'(0) - p : p;
    sel = op[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    if (op[2]) begin
      finish_result = neg ? XLEN'(0) - sel : sel;
    end else if (op == 3'd0) begin
      finish_result = pm[XLEN-1:0];
    end else begin
      finish_result = pm[2*XLEN-1:XLEN];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Operand conditioning at accept
  // --------------------------------------------------------------------------
  logic [2:0]        w_f;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_neg;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special;
  logic              w_fast;
  logic              w_accept;
  logic [2*XLEN-1:0] w_fast_prod;

  assign w_f        = bus.req_funct3;
  assign w_a_signed = (w_f == 3'd1) || (w_f == 3'd2) || (w_f == 3'd4) || (w_f == 3'd6);
  assign w_b_signed = (w_f == 3'd1) || (w_f == 3'd4) || (w_f == 3'd6);
  assign w_sa       = w_a_signed && bus.req_a[XLEN-1];
  assign w_sb       = w_b_signed && bus.req_b[XLEN-1];
  assign w_abs_a    = w_sa ? XLEN'(0) - bus.req_a : bus.req_a;
  assign w_abs_b    = w_sb ? XLEN'(0) - bus.req_b : bus.req_b;
  // Remainder follows the dividend; product and quotient follow sa^sb.
  assign w_neg      = (w_f[2] && w_f[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div0     = w_f[2] && (bus.req_b == '0);
  // Only DIV (4) and REM (6) are signed divides, both with funct3[0]==0.
  assign w_ovf      = w_f[2] && !w_f[0] && (bus.req_a == MOST_NEG) && (bus.req_b == '1);
  assign w_special  = w_div0 ? (w_f[1] ? bus.req_a : '1)
                             : (w_f[1] ? '0 : bus.req_a);
  assign w_fast     = w_f[2] ? (w_div0 || w_ovf) : (FAST_MUL != 0);
  assign w_accept   = bus.req_valid && (r_state == ST_IDLE) && !bus.flush;

  generate
    if (FAST_MUL != 0) begin : g_fast_mul
      assign w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
    end else begin : g_iter_mul
      assign w_fast_prod = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // One iteration step. r_acc low half starts as |a| and shifts out:
  //   multiply: r_acc = {partial sum, remaining multiplier bits}
  //   divide  : r_acc = {partial remainder, dividend bits / quotient bits}
  // --------------------------------------------------------------------------
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_acc_next;
  logic              w_last;

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_last      = (r_cnt == LAST_CNT);

  always_comb begin
    w_acc_next = r_acc;
    if (r_op[2]) begin
      // Restoring step: keep the trial difference only if it did not borrow.
      if (!w_div_diff[XLEN]) begin
        w_acc_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.req_valid) w_state_next = w_fast ? ST_DONE : ST_CALC;
        ST_CALC: if (w_last)         w_state_next = ST_DONE;
        ST_DONE: if (bus.resp_ready) w_state_next = ST_IDLE;
        default:                     w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (r_state == ST_IDLE);
    bus.resp_valid = (r_state == ST_DONE);
  end

  assign bus.resp_result = r_result;
  assign bus.resp_tag    = r_tag;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_op  <= w_f;
      r_tag <= bus.req_tag;
      r_neg <= w_neg;
      r_opb <= w_abs_b;
      r_acc <= {{XLEN{1'b0}}, w_abs_a};
      r_cnt <= '0;
      if (w_fast) begin
        r_result <= w_f[2] ? w_special : finish_result(w_f, w_neg, w_fast_prod);
      end
    end else if ((r_state == ST_CALC) && !bus.flush) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= finish_result(r_op, r_neg, w_acc_next);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised, multi-cycle RISC-V M-extension unit covering MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It uses an iterative radix-2 shift-add multiplier and a restoring divider, with an optional single-cycle multiplier. It sits beside the combinational ALU in the execute stage and exchanges operands and results over valid/ready handshakes. It carries a destination tag and supports pipeline flush.

Parameters:
XLEN, 32, operand/result width; any even value ≥ 8
TAG_W, 5, width of passthrough tag (destination register index)
FAST_MUL, 0, 1 = multiply ops complete in one cycle via combinational product; 0 = iterative

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_funct3  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  XLEN  rs1 operand
req_b  in  XLEN  rs2 operand
req_tag  in  TAG_W  tag returned with the result
flush  in  1  synchronous kill of any in-flight operation
resp_valid  out  1  result available
resp_ready  in  1  consumer takes the result
resp_result  out  XLEN  result
resp_tag  out  TAG_W  tag of the completed request

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous, active-low, on `reset_n`.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_tag=0, internal counter and accumulators 0.
- States:
  - IDLE → CALC on accept (req_valid & req_ready), except fast-path ops.
  - Fast-path ops: div/rem by zero, signed overflow, and multiplies when FAST_MUL=1. These go IDLE → DONE directly.
  - CALC → DONE when the iteration counter reaches XLEN.
  - DONE → IDLE on resp_valid & resp_ready.
- req_ready = (state==IDLE). No overlap: a new request is accepted only after the previous response handshake. The earliest next accept is the cycle after the response handshake.
- Latency, in edges from the accept edge until resp_valid is high:
  - iterative ops: XLEN+1 (one operand-conditioning edge plus XLEN iteration edges);
  - fast-path ops: 1.
- Operand conditioning at accept:
  - Signed ops take the absolute values of their signed operands.
  - For MULHSU, only req_a is treated as signed.
  - Result sign is recorded: for mul, the XOR of the signed operand signs; for quotient, sign(a)^sign(b); for remainder, sign(a).
  - The final result is negated in two's complement when the recorded sign is 1.
- Multiply: 2·XLEN product. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide special cases (RISC-V spec, mandatory):
  - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - DIV with a = most-negative value and b = all ones (−1): quotient = a, REM = 0.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Funct3 and tag are latched at accept. The unit ignores req_* while not in IDLE.
- DONE:
  - resp_result and resp_tag stay stable while resp_valid=1 and resp_ready=0, for any duration.
  - resp_valid deasserts the edge after the handshake.
- flush:
  - Any state → IDLE on the next edge; resp_valid=0 on that edge; no response is produced.
  - flush wins over a same-cycle accept (the request is dropped) and over a same-cycle response handshake (treated as a kill; the consumer must ignore it).
- Asynchronous reset mid-operation forces all reset values immediately. The first post-reset request must compute correctly with no stale accumulator effects.
- All internal arithmetic uses XLEN+1 or 2·XLEN bits. No truncation until the final result selection.

Test Plan:
- MUL/MULH/MULHSU/MULHU with a=b=0xFFFFFFFF, FAST_MUL=0 → results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE; resp_valid 33 edges after accept; tag echoed.
- DIV/REM with a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD, 0xFFFFFFFF. DIVU/REMU with a=100, b=7 → 14, 2. Latency 33.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 and REM → 0. DIVU/REMU a=7, b=0 → 0xFFFFFFFF and 7. Each with latency 1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → result/tag stable, req_ready=0, a pending req_valid is not accepted. After the handshake, req_ready=1 on the next cycle.
- Flush at edge 10 of a DIV → IDLE next edge, no resp_valid. A following MUL 6×7 returns 42. Flush coincident with req_valid in IDLE → request dropped.
- Deassert reset_n mid-CALC → outputs reset immediately. After release, DIVU 0xFFFFFFFF/3 → 0x55555555. With FAST_MUL=1, MUL 3×5 → 15 with latency 1.
